clk_enable_gen: RTL

- Parametrised, fully synchronous clock-enable and divided-clock generator replacing ad-hoc clock manipulation in the pipeline.
- Produces NUM_CH independent enable pulses and registered divided-clock levels from a single clk_in.
- Each channel's divisor is runtime-programmable; a new divisor takes effect only at that channel's period boundary.
- Used to pace slow peripherals and stage-stepping logic without creating new clock domains.

---
 rtl/clk_enable_gen.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
//
// Purpose:
//   Fully synchronous clock-enable and divided-clock generator. Each of NUM_CH
//   channels counts clk_in cycles modulo its active divisor N (a divisor of 0
//   behaves as 1). Each channel produces:
//     - a one-cycle enable pulse (ce_out) once per period, and
//     - a registered divided-clock level (clk_div_out) with high time ceil(N/2).
//   No new clock domain is created; downstream logic stays on clk_in and uses
//   ce_out as an enable.
//   A divisor written at runtime is held pending. It becomes active only at
//   the channel's next period boundary, or on the next edge while the channel
//   is idle. The switch is signalled by a one-cycle div_ack pulse.
//
// Optional feature (macro CLK_ENABLE_GEN_SYNC_ALIGN_EN):
//   When defined, the input sync_in is added. A high sync_in on an edge
//   restarts every channel from phase zero and applies all pending divisors,
//   so channels with equal divisors pulse together afterwards.
//
// Ports:
//   clk_in       in   1       system clock, rising edge
//   rst          in   1       asynchronous active-high reset
//   run          in   1       global run; low holds all channels idle
//   sync_in      in   1       phase-align strobe (only with the macro above)
//   div_wr       in   NUM_CH  per-channel divisor write strobe
//   div_data     in   CNT_W   divisor value shared by all channels
//   div_ack      out  NUM_CH  one-cycle pulse when a pending divisor is applied
//   ce_out       out  NUM_CH  one-cycle enable pulse per period
//   clk_div_out  out  NUM_CH  registered divided-clock level
//   busy         out  1       any channel has a pending divisor
// -----------------------------------------------------------------------------
module clk_enable_gen #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              run,
`ifdef CLK_ENABLE_GEN_SYNC_ALIGN_EN
    input  logic              sync_in,
`endif
    input  logic [NUM_CH-1:0] div_wr,
    input  logic [CNT_W-1:0]  div_data,
    output logic [NUM_CH-1:0] div_ack,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] clk_div_out,
    output logic              busy
);

    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RST_DIV_C = CNT_W'(DEFAULT_DIV);

    // A programmed divisor of zero is treated as one.
    function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
        logic [CNT_W-1:0] n;
        if (d == ZERO_C) begin
            n = ONE_C;
        end else begin
            n = d;
        end
        return n;
    endfunction

    // Return ceil(n/2). This is the number of high cycles of the divided clock.
    function automatic logic [CNT_W-1:0] ceil_half(input logic [CNT_W-1:0] n);
        return (n >> 1) + {{(CNT_W-1){1'b0}}, n[0]};
    endfunction

    // Force all channels to phase zero. This happens when stopped or, if
    // enabled, on sync_in.
    logic force_s;
`ifdef CLK_ENABLE_GEN_SYNC_ALIGN_EN
    assign force_s = ~run | sync_in;
`else
    assign force_s = ~run;
`endif

    logic [NUM_CH-1:0] pend_nxt_vec_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_nxt_s;
        logic [CNT_W-1:0] cnt_inc_s;
        logic [CNT_W-1:0] div_act_r;
        logic [CNT_W-1:0] div_act_nxt_s;
        logic [CNT_W-1:0] div_pend_r;
        logic [CNT_W-1:0] div_pend_nxt_s;
        logic [CNT_W-1:0] n_s;
        logic [CNT_W-1:0] half_s;
        logic             pend_r;
        logic             pend_nxt_s;
        logic             wrap_s;
        logic             apply_s;
        logic             ce_r;
        logic             ce_nxt_s;
        logic             clkd_r;
        logic             clkd_nxt_s;
        logic             ack_r;

        // Period decode: effective divisor, high time, wrap and apply condition.
        always_comb begin
            n_s       = eff_div(div_act_r);
            half_s    = ceil_half(n_s);
            cnt_inc_s = cnt_r + ONE_C;
            wrap_s    = (cnt_r == (n_s - ONE_C));
            // pend_r reflects captures from earlier edges only. A write in the
            // wrap cycle therefore waits for the following boundary.
            apply_s   = pend_r & (wrap_s | force_s);
        end

        // Next counter phase, enable pulse and divided-clock level.
        always_comb begin
            cnt_nxt_s  = cnt_r;
            ce_nxt_s   = 1'b0;
            clkd_nxt_s = 1'b0;
            if (force_s) begin
                cnt_nxt_s  = ZERO_C;
                ce_nxt_s   = 1'b0;
                clkd_nxt_s = 1'b0;
            end else if (wrap_s) begin
                // The next phase is 0, which is always inside the high time.
                cnt_nxt_s  = ZERO_C;
                ce_nxt_s   = 1'b1;
                clkd_nxt_s = 1'b1;
            end else begin
                cnt_nxt_s  = cnt_inc_s;
                ce_nxt_s   = 1'b0;
                clkd_nxt_s = (cnt_inc_s < half_s);
            end
        end

        // Divisor handshake: capture on write, promote to active on apply.
        always_comb begin
            div_act_nxt_s  = div_act_r;
            div_pend_nxt_s = div_pend_r;
            pend_nxt_s     = pend_r;
            if (apply_s) begin
                div_act_nxt_s = div_pend_r;
            end else begin
                div_act_nxt_s = div_act_r;
            end
            // A write in the apply cycle becomes the next pending value.
            if (div_wr[g]) begin
                div_pend_nxt_s = div_data;
                pend_nxt_s     = 1'b1;
            end else if (apply_s) begin
                div_pend_nxt_s = div_pend_r;
                pend_nxt_s     = 1'b0;
            end else begin
                div_pend_nxt_s = div_pend_r;
                pend_nxt_s     = pend_r;
            end
        end

        // Channel state registers.
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                cnt_r      <= ZERO_C;
                div_act_r  <= RST_DIV_C;
                div_pend_r <= ZERO_C;
                pend_r     <= 1'b0;
                ce_r       <= 1'b0;
                clkd_r     <= 1'b0;
                ack_r      <= 1'b0;
            end else begin
                cnt_r      <= cnt_nxt_s;
                div_act_r  <= div_act_nxt_s;
                div_pend_r <= div_pend_nxt_s;
                pend_r     <= pend_nxt_s;
                ce_r       <= ce_nxt_s;
                clkd_r     <= clkd_nxt_s;
                ack_r      <= apply_s;
            end
        end

        assign pend_nxt_vec_s[g] = pend_nxt_s;
        assign ce_out[g]         = ce_r;
        assign clk_div_out[g]    = clkd_r;
        assign div_ack[g]        = ack_r;
    end

    logic busy_r;

    // Registered busy. It always equals the OR of the per-channel pending flags.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= |pend_nxt_vec_s;
        end
    end

    assign busy = busy_r;

endmodule
